// File: rtl/alu_share_arbiter.sv
`default_nettype none
// ============================================================================
// alu_share_arbiter : round-robin sharing of one combinational ALU between
// NREQ valid/ready requesters, with a single registered, id-tagged response slot.
// Revision: 1.0
// ============================================================================
module alu_share_arbiter #(
  parameter int NREQ = 2,
  parameter int XLEN = 32,
  parameter int ID_W = (NREQ > 2) ? $clog2(NREQ) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*XLEN-1:0] req_a,
  input  logic [NREQ*XLEN-1:0] req_b,
  input  logic [NREQ*4-1:0]    req_op,
  output logic [XLEN-1:0]      alu_a,
  output logic [XLEN-1:0]      alu_b,
  output logic [3:0]           alu_op,
  input  logic [XLEN-1:0]      alu_result,
  input  logic                 alu_zero,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [ID_W-1:0]      rsp_id,
  output logic [XLEN-1:0]      rsp_result,
  output logic                 rsp_zero,
  output logic [31:0]          op_count
);

  typedef enum logic [0:0] {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [ID_W-1:0] r_rr_ptr;
  logic [ID_W-1:0] r_rsp_id;
  logic [XLEN-1:0] r_rsp_result;
  logic            r_rsp_zero;
  logic [31:0]     r_op_count;

  logic            w_any;
  logic [ID_W-1:0] w_grant;
  logic [NREQ-1:0] w_grant_oh;
  logic            w_can_accept;
  logic            w_accept;

  // Rotating priority scan starting at r_rr_ptr; the first hit also steers the ALU mux.
  always_comb begin
    w_any      = 1'b0;
    w_grant    = '0;
    w_grant_oh = '0;
    alu_a      = '0;
    alu_b      = '0;
    alu_op     = 4'b0000;
    for (int k = 0; k < NREQ; k++) begin
      int idx;
      idx = (int'(r_rr_ptr) + k) % NREQ;
      if (!w_any && req_valid[idx]) begin
        w_any           = 1'b1;
        w_grant         = idx[ID_W-1:0];
        w_grant_oh[idx] = 1'b1;
        alu_a           = req_a[idx*XLEN +: XLEN];
        alu_b           = req_b[idx*XLEN +: XLEN];
        alu_op          = req_op[idx*4 +: 4];
      end
    end
  end

  // rst gating keeps requesters from seeing a handshake the flops will never take.
  assign w_can_accept = ((r_state == ST_EMPTY) || rsp_ready) && !rst;
  assign req_ready    = w_can_accept ? w_grant_oh : '0;
  assign w_accept     = w_any && w_can_accept;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_EMPTY: if (w_accept) w_state_nxt = ST_FULL;
      ST_FULL: begin
        if (w_accept)       w_state_nxt = ST_FULL;
        else if (rsp_ready) w_state_nxt = ST_EMPTY;
      end
      default: w_state_nxt = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_EMPTY;
      r_rr_ptr     <= '0;
      r_rsp_id     <= '0;
      r_rsp_result <= '0;
      r_rsp_zero   <= 1'b0;
      r_op_count   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_rsp_id     <= w_grant;
        r_rsp_result <= alu_result;
        r_rsp_zero   <= alu_zero;
        r_rr_ptr     <= (w_grant == ID_W'(NREQ - 1)) ? '0 : w_grant + ID_W'(1);
        r_op_count   <= r_op_count + 32'd1;
      end
    end
  end

  assign rsp_valid  = (r_state == ST_FULL);
  assign rsp_id     = r_rsp_id;
  assign rsp_result = r_rsp_result;
  assign rsp_zero   = r_rsp_zero;
  assign op_count   = r_op_count;

endmodule
`default_nettype wire

// File: tb/tb_alu_share_arbiter.sv
`default_nettype none
// ============================================================================
// tb_alu_share_arbiter : directed and random checks of alu_share_arbiter
// against a transaction-level model. Revision: 1.0
// ============================================================================
module tb_alu_share_arbiter;
  localparam int NREQ = 2;
  localparam int XLEN = 32;
  localparam int ID_W = 1;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NREQ-1:0]      req_valid, req_ready;
  logic [NREQ*XLEN-1:0] req_a, req_b;
  logic [NREQ*4-1:0]    req_op;
  logic [XLEN-1:0]      alu_a, alu_b, alu_result, rsp_result;
  logic [3:0]           alu_op;
  logic                 alu_zero, rsp_valid, rsp_ready, rsp_zero;
  logic [ID_W-1:0]      rsp_id;
  logic [31:0]          op_count;

  alu_share_arbiter #(.NREQ(NREQ), .XLEN(XLEN), .ID_W(ID_W)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_result(alu_result), .alu_zero(alu_zero),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_zero(rsp_zero), .op_count(op_count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] alu_f(input logic [31:0] a, input logic [31:0] b,
                                        input logic [3:0] op);
    case (op)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a & b;
      4'd3:    return a | b;
      4'd4:    return a ^ b;
      4'd5:    return a << b[4:0];
      4'd6:    return a >> b[4:0];
      4'd7:    return $unsigned($signed(a) >>> b[4:0]);
      4'd8:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  // The shared ALU itself lives in the bench.
  always_comb begin
    alu_result = alu_f(alu_a, alu_b, alu_op);
    alu_zero   = (alu_result == 32'd0);
  end

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Request fields per requester, and the transaction-level model of the slot.
  logic [31:0] va[NREQ];
  logic [31:0] vb[NREQ];
  logic [3:0]  vo[NREQ];
  int          m_ptr;
  bit          m_full;
  int          m_id;
  logic [31:0] m_res;
  bit          m_zero;
  logic [31:0] m_cnt;

  task automatic model_reset();
    m_ptr = 0; m_full = 0; m_id = 0; m_res = 0; m_zero = 0; m_cnt = 0;
  endtask

  task automatic set_req(input int i, input bit v, input logic [31:0] a,
                         input logic [31:0] b, input logic [3:0] op);
    req_valid[i]        = v;
    va[i] = a; vb[i] = b; vo[i] = op;
    req_a[i*XLEN +: XLEN] = a;
    req_b[i*XLEN +: XLEN] = b;
    req_op[i*4 +: 4]      = op;
  endtask

  // One clock: check combinational outputs, advance model across the edge, check the slot.
  task automatic cycle();
    int g;
    bit can;
    logic [NREQ-1:0] exp_ready;
    #1;
    g = -1;
    for (int k = 0; k < NREQ; k++)
      if (g < 0 && req_valid[(m_ptr + k) % NREQ]) g = (m_ptr + k) % NREQ;
    can = !m_full || rsp_ready;
    exp_ready = '0;
    if (g >= 0 && can) exp_ready[g] = 1'b1;
    chk("req_ready", 32'(req_ready), 32'(exp_ready));
    chk("alu_a",  alu_a,  (g >= 0) ? va[g] : 32'd0);
    chk("alu_b",  alu_b,  (g >= 0) ? vb[g] : 32'd0);
    chk("alu_op", 32'(alu_op), (g >= 0) ? 32'(vo[g]) : 32'd0);
    @(posedge clk);
    if (g >= 0 && can) begin
      m_full = 1;
      m_res  = alu_f(va[g], vb[g], vo[g]);
      m_zero = (m_res == 0);
      m_id   = g;
      m_ptr  = (g + 1) % NREQ;
      m_cnt  = m_cnt + 1;
    end else if (m_full && rsp_ready) begin
      m_full = 0;
    end
    #1;
    chk("rsp_valid",  32'(rsp_valid), 32'(m_full));
    chk("rsp_id",     32'(rsp_id), 32'(m_id));
    chk("rsp_result", rsp_result, m_res);
    chk("rsp_zero",   32'(rsp_zero), 32'(m_zero));
    chk("op_count",   op_count, m_cnt);
  endtask

  initial begin
    rst = 1'b1;
    rsp_ready = 1'b0;
    req_valid = '0; req_a = '0; req_b = '0; req_op = '0;
    for (int i = 0; i < NREQ; i++) set_req(i, 1'b0, 32'd0, 32'd0, 4'd0);
    model_reset();

    // Reset state; a valid request must not see ready while rst is high.
    set_req(0, 1'b1, 32'd1, 32'd1, 4'd0);
    #12;
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset_rsp_result", rsp_result, 32'd0);
    chk("reset_op_count", op_count, 32'd0);
    chk("reset_req_ready", 32'(req_ready), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Single request: 5 + 3.
    set_req(0, 1'b1, 32'd5, 32'd3, 4'd0);
    rsp_ready = 1'b1;
    cycle();
    chk("single_result", rsp_result, 32'd8);
    chk("single_count", op_count, 32'd1);

    // Round-robin with both valid; every result is zero.
    set_req(0, 1'b1, 32'd7, 32'd7, 4'd1);
    set_req(1, 1'b1, 32'd0, 32'd0, 4'd3);
    for (int n = 0; n < 4; n++) begin
      cycle();
      chk("rr_zero", 32'(rsp_zero), 32'd1);
    end
    chk("rr_count", op_count, 32'd5);

    // Backpressure after req1 SLT 2<9.
    set_req(0, 1'b0, 32'd0, 32'd0, 4'd0);
    set_req(1, 1'b1, 32'd2, 32'd9, 4'd8);
    cycle();
    chk("slt_result", rsp_result, 32'd1);
    rsp_ready = 1'b0;
    set_req(0, 1'b1, 32'd40, 32'd2, 4'd0);
    for (int n = 0; n < 5; n++) begin
      cycle();
      chk("bp_held", rsp_result, 32'd1);
    end
    rsp_ready = 1'b1;
    cycle();
    chk("bp_release_id", 32'(rsp_id), 32'd0);
    chk("bp_release_result", rsp_result, 32'd42);

    // Drain to empty.
    set_req(0, 1'b0, 32'd0, 32'd0, 4'd0);
    set_req(1, 1'b0, 32'd0, 32'd0, 4'd0);
    cycle();
    chk("drain_result_kept", rsp_result, 32'd42);

    // Async reset mid-cycle while FULL with req1 pending.
    rsp_ready = 1'b0;
    set_req(1, 1'b1, 32'd11, 32'd4, 4'd1);
    cycle();
    #2 rst = 1'b1;
    #1;
    chk("async_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("async_op_count", op_count, 32'd0);
    chk("async_req_ready", 32'(req_ready), 32'd0);
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    rsp_ready = 1'b1;
    set_req(0, 1'b1, 32'd3, 32'd4, 4'd2);
    cycle();
    chk("post_reset_id", 32'(rsp_id), 32'd0);

    // Random traffic against the model.
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < NREQ; i++)
        set_req(i, 1'($urandom_range(0, 1)), $urandom(),
                ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom(),
                4'($urandom_range(0, 8)));
      if ($urandom_range(0, 7) == 0) begin
        set_req(0, 1'b1, 32'd6, 32'd6, 4'd1);
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish, expected finish");
    $fatal(1, "timeout");
  end
endmodule
`default_nettype wire
